serial_sub_ctrl: RTL
====================

SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in to bit 0.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow out of MSB.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL assert in_ready only in IDLE.
REQ-016 SHALL, in IDLE with in_valid=1, capture a, b, bin into internal registers, clear bit index to 0, and enter RUN.
REQ-017 SHALL in RUN process one bit per cycle through a single 1-bit full-subtractor cell: diff bit i = a[i]^b[i]^borrow, borrow' = (~a[i]&b[i]) | (~(a[i]^b[i])&borrow).
REQ-018 SHALL store each diff bit at index i, register borrow' for the next bit, increment index.
REQ-019 SHALL leave RUN for DONE after bit WIDTH-1 is processed; latency from accepting handshake to out_valid=1 is exactly WIDTH+1 clock edges.
REQ-020 SHALL in DONE hold out_valid=1 with diff and bout stable until out_ready=1, then return to IDLE on that edge.
REQ-021 SHALL ignore in_valid and a/b/bin changes while in RUN or DONE (no re-capture, no abort).
REQ-022 SHALL allow out_ready held high permanently: DONE lasts exactly one cycle, IDLE follows.
REQ-023 SHALL keep diff/bout at last completed result while in IDLE and RUN; out_valid=0 outside DONE.
REQ-024 SHALL use an index counter of width $clog2(WIDTH) and SHALL NOT wrap past WIDTH-1.

Reset
REQ-025 SHALL on rst_n=0, regardless of state (including mid-RUN), asynchronously force state=IDLE, index=0, borrow=0, diff=0, bout=0, out_valid=0, busy=0, in_ready=1 after deassertion.
REQ-026 SHALL discard any partially computed result on reset; no out_valid for the aborted operation.

Configuration
REQ-027 SHALL with macro SERIAL_SUB_OVF_EN defined add output port ovf (1 bit): signed overflow = (a[MSB]^b[MSB]) & (a[MSB]^diff[MSB]), valid with out_valid, reset 0.
REQ-028 SHALL without SERIAL_SUB_OVF_EN omit port ovf and all its logic; remaining behaviour is unchanged.

Structure
REQ-029 SHALL place FSM state enumeration (IDLE/RUN/DONE) and default WIDTH constant in shared package serial_sub_pkg.
REQ-030 SHALL instantiate exactly one sub-module fs_bit (inputs a, b, bin; outputs d, bo) as the combinational 1-bit cell.

Verification
REQ-031 SHALL test WIDTH=8: a=8'h5A, b=8'h21, bin=0 -> after 9 edges out_valid=1, diff=8'h39, bout=0.
REQ-032 SHALL test underflow: a=8'h00, b=8'h01, bin=0 -> diff=8'hFF, bout=1; with OVF_EN a=8'h80, b=8'h01 -> diff=8'h7F, ovf=1.
REQ-033 SHALL test borrow-in: a=8'h10, b=8'h10, bin=1 -> diff=8'hFF, bout=1.
REQ-034 SHALL test backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, diff stable, in_ready=0; new in_valid ignored until return to IDLE.
REQ-035 SHALL test reset mid-RUN: rst_n=0 at bit index 3 -> immediately state IDLE, diff=0, out_valid=0; following request a=8'h03, b=8'h01 -> diff=8'h02.
REQ-036 SHALL test back-to-back: in_valid and out_ready held 1 for 4 operations -> each result spaced WIDTH+2 cycles, all match a-b-bin reference model.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM states and default width for the bit-serial subtractor
package serial_sub_pkg;

  localparam int SUB_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/fs_bit.sv
// rtl/fs_bit.sv - combinational 1-bit full-subtractor cell
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial a-b-bin controller, one bit per clock through fs_bit
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             borrow_q, borrow_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             in_ready_q, in_ready_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic cell_d;
  logic cell_bo;

  fs_bit u_fs_bit (
    .a   (a_q[idx_q]),
    .b   (b_q[idx_q]),
    .bin (borrow_q),
    .d   (cell_d),
    .bo  (cell_bo)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    acc_d    = acc_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_d[idx_q] = cell_d;
        borrow_d     = cell_bo;
        if (idx_q == LAST_IDX) begin
          // Publish the full word only on completion so diff never shows a partial result.
          state_d = DONE;
          diff_d  = acc_d;
          bout_d  = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ cell_d);
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    in_ready_d  = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      borrow_q    <= 1'b0;
      acc_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_q         <= a_d;
      b_q         <= b_d;
      borrow_q    <= borrow_d;
      acc_q       <= acc_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign busy      = busy_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule
